xbar_sched: RTL and testbench

- Per-output, packet-granular round-robin scheduler for the switch crossbar datapath.
- Accepts one unicast connection request per input port (destination index). Grants each output to at most one input at a time and drives the crossbar per-output select vector.
- Holds each connection until the granted input's last beat is accepted, or until a stall watchdog expires.
- Sits between the ingress queue heads and the crossbar mux.

---
 rtl/xbar_sched.sv | 156 +++++++++++++++
 tb/tb_xbar_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_sched.sv
// xbar_sched: per-output round-robin connection scheduler for the switch crossbar.
// Each output holds one input connected for a whole packet, then takes one bubble
// cycle before it grants again. A per-output watchdog frees a connection whose
// input has stopped sending beats.
//
// Per-output FSM
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | output free; arbitrating among requesters addressed to it
//   ST_BUSY | output holds xbar_arbit[o]; waiting for last beat or timeout
module xbar_sched #(
    parameter int XBAR_INPUT    = 4,
    parameter int XBAR_INPUT_L2 = $clog2(XBAR_INPUT),
    parameter int TMO_CYCLES    = 1024,
    parameter int TMO_W         = $clog2(TMO_CYCLES + 1)
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic [XBAR_INPUT-1:0]                      req_valid,
    input  logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0]   req_dst,
    input  logic [XBAR_INPUT-1:0]                      beat_valid,
    input  logic [XBAR_INPUT-1:0]                      beat_last,
    input  logic [XBAR_INPUT-1:0]                      out_ready,
    output logic [XBAR_INPUT-1:0]                      in_gnt,
    output logic [XBAR_INPUT-1:0]                      in_ready,
    output logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0]   xbar_arbit,
    output logic [XBAR_INPUT-1:0]                      out_busy,
    output logic [XBAR_INPUT-1:0]                      out_valid,
    output logic [XBAR_INPUT-1:0]                      tmo_pulse
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                                    state_q [XBAR_INPUT];
    logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0]  ptr_q;
    logic [XBAR_INPUT-1:0][TMO_W-1:0]          wdog_q;

    logic [XBAR_INPUT-1:0]                     acc;
    logic [XBAR_INPUT-1:0]                     rel_norm;
    logic [XBAR_INPUT-1:0]                     rel_tmo;
    logic [XBAR_INPUT-1:0]                     gnt_found;
    logic [XBAR_INPUT-1:0][XBAR_INPUT_L2-1:0]  gnt_pick;
    logic [XBAR_INPUT-1:0]                     gnt_mask;
    logic [XBAR_INPUT-1:0]                     rel_mask;

    // Beat handshake: an input's beat is accepted when the output it holds is ready.
    always_comb begin
        in_ready = '0;
        for (int o = 0; o < XBAR_INPUT; o++) begin
            if (out_busy[o] && in_gnt[xbar_arbit[o]] && beat_valid[xbar_arbit[o]] && out_ready[o]) begin
                in_ready[xbar_arbit[o]] = 1'b1;
            end
        end
    end

    // Per-output view of the held connection: beat present, beat accepted, release causes.
    always_comb begin
        out_valid = '0;
        acc       = '0;
        rel_norm  = '0;
        rel_tmo   = '0;
        for (int o = 0; o < XBAR_INPUT; o++) begin
            out_valid[o] = out_busy[o] & beat_valid[xbar_arbit[o]];
            acc[o]       = out_busy[o] & in_ready[xbar_arbit[o]];
            rel_norm[o]  = acc[o] & beat_last[xbar_arbit[o]];
            // A last beat landing on the final watchdog cycle wins: acc masks the timeout.
            rel_tmo[o]   = out_busy[o] & ~acc[o] & (wdog_q[o] == TMO_W'(TMO_CYCLES - 1));
        end
    end

    // Round-robin pick per output: first eligible requester at or after ptr, wrapping.
    always_comb begin
        logic [XBAR_INPUT_L2-1:0] cand;
        int                       idx;
        cand      = '0;
        idx       = 0;
        gnt_found = '0;
        gnt_pick  = '0;
        for (int o = 0; o < XBAR_INPUT; o++) begin
            for (int k = 0; k < XBAR_INPUT; k++) begin
                idx  = (int'(ptr_q[o]) + k) % XBAR_INPUT;
                cand = XBAR_INPUT_L2'(idx);
                if (!gnt_found[o] && req_valid[cand] && !in_gnt[cand] &&
                    (req_dst[cand] == XBAR_INPUT_L2'(o))) begin
                    gnt_found[o] = 1'b1;
                    gnt_pick[o]  = cand;
                end
            end
        end
    end

    // Input-side grant bookkeeping: inputs gained by IDLE outputs, inputs freed by releases.
    always_comb begin
        gnt_mask = '0;
        rel_mask = '0;
        for (int o = 0; o < XBAR_INPUT; o++) begin
            if (state_q[o] == ST_IDLE && gnt_found[o]) begin
                gnt_mask[gnt_pick[o]] = 1'b1;
            end
            if (rel_norm[o] || rel_tmo[o]) begin
                rel_mask[xbar_arbit[o]] = 1'b1;
            end
        end
    end

    // Output FSMs, RR pointers, watchdogs and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int o = 0; o < XBAR_INPUT; o++) begin
                state_q[o] <= ST_IDLE;
            end
            ptr_q      <= '0;
            wdog_q     <= '0;
            in_gnt     <= '0;
            out_busy   <= '0;
            xbar_arbit <= '0;
            tmo_pulse  <= '0;
        end else begin
            in_gnt    <= (in_gnt & ~rel_mask) | gnt_mask;
            tmo_pulse <= rel_tmo;
            for (int o = 0; o < XBAR_INPUT; o++) begin
                case (state_q[o])
                    ST_IDLE: begin
                        if (gnt_found[o]) begin
                            state_q[o]    <= ST_BUSY;
                            out_busy[o]   <= 1'b1;
                            xbar_arbit[o] <= gnt_pick[o];
                            ptr_q[o]      <= (gnt_pick[o] == XBAR_INPUT_L2'(XBAR_INPUT - 1)) ?
                                             '0 : gnt_pick[o] + XBAR_INPUT_L2'(1);
                            wdog_q[o]     <= '0;
                        end
                    end
                    ST_BUSY: begin
                        if (rel_norm[o] || rel_tmo[o]) begin
                            // xbar_arbit[o] deliberately keeps the last select
                            state_q[o]  <= ST_IDLE;
                            out_busy[o] <= 1'b0;
                        end else if (acc[o]) begin
                            wdog_q[o] <= '0;
                        end else if (wdog_q[o] != TMO_W'(TMO_CYCLES)) begin
                            wdog_q[o] <= wdog_q[o] + TMO_W'(1);
                        end
                    end
                    default: begin
                        state_q[o]  <= ST_IDLE;
                        out_busy[o] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xbar_sched.sv
// Directed bench for xbar_sched (4 ports, watchdog shortened to 8 cycles).
// Inputs change 1 ns after a rising edge; checks run 1 ns later, mid-cycle.
module tb_xbar_sched;

    localparam int N  = 4;
    localparam int L2 = 2;

    logic                 clk;
    logic                 rstn;
    logic [N-1:0]         req_valid;
    logic [N-1:0][L2-1:0] req_dst;
    logic [N-1:0]         beat_valid;
    logic [N-1:0]         beat_last;
    logic [N-1:0]         out_ready;
    logic [N-1:0]         in_gnt;
    logic [N-1:0]         in_ready;
    logic [N-1:0][L2-1:0] xbar_arbit;
    logic [N-1:0]         out_busy;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         tmo_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    xbar_sched #(
        .XBAR_INPUT (N),
        .TMO_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_dst    (req_dst),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .out_ready  (out_ready),
        .in_gnt     (in_gnt),
        .in_ready   (in_ready),
        .xbar_arbit (xbar_arbit),
        .out_busy   (out_busy),
        .out_valid  (out_valid),
        .tmo_pulse  (tmo_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int rr_exp [6];
        rr_exp = '{0, 1, 3, 0, 1, 3};

        rstn       = 1'b0;
        req_valid  = '0;
        req_dst    = '0;
        beat_valid = '0;
        beat_last  = '0;
        out_ready  = '1;

        // reset values
        nxt(); nxt();
        chk("rst_in_gnt",   32'(in_gnt),     32'h0);
        chk("rst_out_busy", 32'(out_busy),   32'h0);
        chk("rst_tmo",      32'(tmo_pulse),  32'h0);
        chk("rst_arbit",    32'(xbar_arbit), 32'h0);
        rstn = 1'b1;
        nxt(); nxt();

        // A: input 2 -> output 1, 4-beat packet
        req_valid  = 4'b0100;
        req_dst[2] = 2'd1;
        beat_valid = 4'b0100;
        #1;
        chk("a_pre_gnt",   32'(in_gnt),    32'h0);
        chk("a_pre_valid", 32'(out_valid), 32'h0);
        nxt();
        req_valid = '0;
        #1;
        chk("a_in_gnt",   32'(in_gnt),        32'b0100);
        chk("a_out_busy", 32'(out_busy),      32'b0010);
        chk("a_arbit1",   32'(xbar_arbit[1]), 32'd2);
        chk("a_in_ready", 32'(in_ready),      32'b0100);
        chk("a_out_vld",  32'(out_valid),     32'b0010);
        nxt(); nxt(); nxt();
        beat_last = 4'b0100;
        #1;
        chk("a_last_rdy",  32'(in_ready), 32'b0100);
        chk("a_last_busy", 32'(out_busy), 32'b0010);
        nxt();
        beat_valid = '0;
        beat_last  = '0;
        #1;
        chk("a_rel_busy",  32'(out_busy),      32'h0);
        chk("a_rel_gnt",   32'(in_gnt),        32'h0);
        chk("a_rel_arbit", 32'(xbar_arbit[1]), 32'd2);
        chk("a_rel_tmo",   32'(tmo_pulse),     32'h0);
        nxt();

        // B: inputs 0,1,3 contend for output 0 with single-beat packets
        req_valid  = 4'b1011;
        req_dst    = '0;
        beat_valid = 4'b1011;
        beat_last  = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            nxt();
            #1;
            chk("b_gnt",   32'(in_gnt),        32'(1 << rr_exp[k]));
            chk("b_arbit", 32'(xbar_arbit[0]), 32'(rr_exp[k]));
            chk("b_busy",  32'(out_busy),      32'b0001);
            nxt();
            #1;
            chk("b_bubble", 32'(out_busy), 32'h0);
        end
        req_valid  = '0;
        beat_valid = '0;
        beat_last  = '0;
        nxt();
        #1;
        chk("b_no_regrant", 32'(out_busy), 32'h0);

        // C: input 1 -> output 3, no beats; watchdog of 8 cycles
        req_valid  = 4'b0010;
        req_dst[1] = 2'd3;
        nxt();
        req_valid = '0;
        #1;
        chk("c_gnt",  32'(in_gnt),   32'b0010);
        chk("c_busy", 32'(out_busy), 32'b1000);
        for (int k = 2; k <= 8; k++) begin
            nxt();
            #1;
            chk("c_hold_busy", 32'(out_busy),  32'b1000);
            chk("c_hold_tmo",  32'(tmo_pulse), 32'h0);
        end
        nxt();
        #1;
        chk("c_tmo_pulse", 32'(tmo_pulse), 32'b1000);
        chk("c_tmo_busy",  32'(out_busy),  32'h0);
        chk("c_tmo_gnt",   32'(in_gnt),    32'h0);
        nxt();
        #1;
        chk("c_tmo_one", 32'(tmo_pulse), 32'h0);

        // D: input 0 -> output 2 and input 3 -> output 1 together;
        //    then output 2 stalls the last beat for 5 cycles
        req_valid  = 4'b1001;
        req_dst[0] = 2'd2;
        req_dst[3] = 2'd1;
        beat_valid = 4'b1001;
        beat_last  = 4'b1000;
        nxt();
        req_valid = '0;
        #1;
        chk("d_gnt",    32'(in_gnt),        32'b1001);
        chk("d_busy",   32'(out_busy),      32'b0110);
        chk("d_arbit2", 32'(xbar_arbit[2]), 32'd0);
        chk("d_arbit1", 32'(xbar_arbit[1]), 32'd3);
        chk("d_rdy",    32'(in_ready),      32'b1001);
        nxt();
        beat_valid = 4'b0001;
        beat_last  = 4'b0001;
        out_ready  = 4'b1011;
        #1;
        chk("d_busy_split", 32'(out_busy), 32'b0100);
        chk("d_gnt_split",  32'(in_gnt),   32'b0001);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            #1;
            chk("e_stall_rdy",  32'(in_ready),  32'h0);
            chk("e_stall_busy", 32'(out_busy),  32'b0100);
            chk("e_stall_vld",  32'(out_valid), 32'b0100);
        end
        nxt();
        out_ready = '1;
        #1;
        chk("e_rise_rdy", 32'(in_ready), 32'b0001);
        nxt();
        beat_valid = '0;
        beat_last  = '0;
        #1;
        chk("e_rel_busy", 32'(out_busy),  32'h0);
        chk("e_rel_gnt",  32'(in_gnt),    32'h0);
        chk("e_rel_tmo",  32'(tmo_pulse), 32'h0);
        nxt();

        // F: asynchronous reset mid-packet, request kept pending
        req_valid  = 4'b0100;
        req_dst[2] = 2'd0;
        beat_valid = 4'b0100;
        nxt();
        #1;
        chk("f_gnt_pre",   32'(in_gnt),        32'b0100);
        chk("f_arbit_pre", 32'(xbar_arbit[0]), 32'd2);
        rstn = 1'b0;
        #1;
        chk("f_rst_gnt",   32'(in_gnt),     32'h0);
        chk("f_rst_busy",  32'(out_busy),   32'h0);
        chk("f_rst_arbit", 32'(xbar_arbit), 32'h0);
        chk("f_rst_tmo",   32'(tmo_pulse),  32'h0);
        nxt();
        rstn = 1'b1;
        #1;
        chk("f_hold_gnt", 32'(in_gnt), 32'h0);
        nxt();
        #1;
        chk("f_regnt",       32'(in_gnt),        32'b0100);
        chk("f_regnt_busy",  32'(out_busy),      32'b0001);
        chk("f_regnt_arbit", 32'(xbar_arbit[0]), 32'd2);
        req_valid  = '0;
        beat_valid = '0;
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
